// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg -- shared definitions for the rectangle streaming block.
//   state_t        : controller states (IDLE / EMIT / DONE)
//   DEFAULT_WIDTH  : default coordinate/counter width
//   FILL_SOLID / FILL_OUTLINE : values of the 'fill' mode input
// ---------------------------------------------------------------------------
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic FILL_SOLID   = 1'b1;
  localparam logic FILL_OUTLINE = 1'b0;

endpackage : draw_pkg

// File: rtl/draw_rectangle_stream_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter -- cx/cy raster position of a rectangle walk.
//   _clock, _reset : clock, synchronous active-high reset
//   load           : restart the walk at (0,0)
//   advance        : step to the next position this cycle
//   outline        : skip interior pixels of interior rows
//   w_m1, h_m1     : width-1 / height-1 of the rectangle (both nonzero-size)
//   cx_adv, cy_adv : the position the walk moves to on 'advance'
//   last           : current position is the bottom-right corner
// ---------------------------------------------------------------------------
module raster_counter
  import draw_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             load,
  input  logic             advance,
  input  logic             outline,
  input  logic [WIDTH-1:0] w_m1,
  input  logic [WIDTH-1:0] h_m1,
  output logic [WIDTH-1:0] cx_adv,
  output logic [WIDTH-1:0] cy_adv,
  output logic             last
);

  logic [WIDTH-1:0] cx;
  logic [WIDTH-1:0] cy;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else leaves a value unassigned and infers a latch.
  always_comb begin
    cx_adv = cx + 1'b1;
    cy_adv = cy;
    last   = (cx == w_m1) && (cy == h_m1);
    if (cx == w_m1) begin
      cx_adv = '0;
      cy_adv = cy + 1'b1;
    end else if (outline && (cx == '0) && (cy != '0) && (cy < h_m1)) begin
      // Interior row of an outline: jump straight from the left edge to the
      // right edge. The cx==w_m1 test above has priority, so width 1 never
      // jumps and width 2 lands on cx=1 exactly as a plain step would.
      cx_adv = w_m1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its inputs.
  always_ff @(posedge _clock) begin
    if (_reset || load) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      cx <= cx_adv;
      cy <= cy_adv;
    end
  end

endmodule : raster_counter

// File: rtl/draw_rectangle_stream.sv
// ---------------------------------------------------------------------------
// draw_rectangle_stream -- streams the pixel coordinates of an axis-aligned
// rectangle in raster order over a valid/ready handshake.
//   _clock, _reset       : clock, synchronous active-high reset
//   _start               : one-cycle pulse, latches arguments, (re)starts
//   s_x, s_y             : top-left corner
//   width, height        : rectangle size in pixels (0 = nothing to draw)
//   fill                 : FILL_SOLID or FILL_OUTLINE, latched on _start
//   _ready               : downstream accepts the current pixel
//   _out0, _out1, _valid : pixel x / y and its valid flag
//   _busy, _done         : drawing in progress / drawing finished (level)
// Build option: define DRAW_RECTANGLE_STREAM_CLIP_EN to suppress pixels that
// fall outside SCREEN_W x SCREEN_H or whose coordinate sum overflowed.
// ---------------------------------------------------------------------------
module draw_rectangle_stream
  import draw_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] s_x,
  input  logic [WIDTH-1:0] s_y,
  input  logic [WIDTH-1:0] width,
  input  logic [WIDTH-1:0] height,
  input  logic             fill,
  input  logic             _ready,
  output logic [WIDTH-1:0] _out0,
  output logic [WIDTH-1:0] _out1,
  output logic             _valid,
  output logic             _busy,
  output logic             _done
);

  state_t           state;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] w_m1;
  logic [WIDTH-1:0] h_m1;
  logic             fill_q;
  logic             clipped;    // current position is suppressed

  logic [WIDTH-1:0] cx_adv;
  logic [WIDTH-1:0] cy_adv;
  logic             last;
  logic             step;
  logic             clip_start;
  logic             clip_adv;

  // A suppressed position moves on without waiting for the consumer.
  assign step = (state == EMIT) && ((_valid && _ready) || clipped);

  raster_counter #(
    .WIDTH (WIDTH)
  ) u_raster (
    ._clock  (_clock),
    ._reset  (_reset),
    .load    (_start),
    .advance (step && !_start),
    .outline (fill_q == FILL_OUTLINE),
    .w_m1    (w_m1),
    .h_m1    (h_m1),
    .cx_adv  (cx_adv),
    .cy_adv  (cy_adv),
    .last    (last)
  );

`ifdef DRAW_RECTANGLE_STREAM_CLIP_EN
  localparam logic [WIDTH:0] CLIP_W = (WIDTH+1)'(SCREEN_W);
  localparam logic [WIDTH:0] CLIP_H = (WIDTH+1)'(SCREEN_H);

  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] sum_y;

  // One extra bit catches a coordinate that wrapped past 2^WIDTH.
  always_comb begin
    sum_x      = {1'b0, x0} + {1'b0, cx_adv};
    sum_y      = {1'b0, y0} + {1'b0, cy_adv};
    clip_adv   = sum_x[WIDTH] || sum_y[WIDTH] || (sum_x >= CLIP_W) || (sum_y >= CLIP_H);
    clip_start = ({1'b0, s_x} >= CLIP_W) || ({1'b0, s_y} >= CLIP_H);
  end
`else
  assign clip_adv   = 1'b0;
  assign clip_start = 1'b0;
`endif

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state   <= IDLE;
      x0      <= '0;
      y0      <= '0;
      w_m1    <= '0;
      h_m1    <= '0;
      fill_q  <= FILL_OUTLINE;
      clipped <= 1'b0;
      _out0   <= '0;
      _out1   <= '0;
      _valid  <= 1'b0;
      _busy   <= 1'b0;
      _done   <= 1'b0;
    end else if (_start) begin
      // Restart from any state; whatever pixel was on offer is dropped.
      x0     <= s_x;
      y0     <= s_y;
      fill_q <= fill;
      w_m1   <= (width  != '0) ? width  - 1'b1 : '0;
      h_m1   <= (height != '0) ? height - 1'b1 : '0;
      _out0  <= s_x;
      _out1  <= s_y;
      if ((width == '0) || (height == '0)) begin
        state   <= DONE;
        clipped <= 1'b0;
        _valid  <= 1'b0;
        _busy   <= 1'b0;
        _done   <= 1'b1;
      end else begin
        state   <= EMIT;
        clipped <= clip_start;
        _valid  <= !clip_start;
        _busy   <= 1'b1;
        _done   <= 1'b0;
      end
    end else begin
      case (state)
        EMIT: begin
          if (step) begin
            if (last) begin
              state   <= DONE;
              clipped <= 1'b0;
              _valid  <= 1'b0;
              _busy   <= 1'b0;
              _done   <= 1'b1;
            end else begin
              _out0   <= x0 + cx_adv;
              _out1   <= y0 + cy_adv;
              clipped <= clip_adv;
              _valid  <= !clip_adv;
            end
          end
        end
        default: ;  // IDLE and DONE hold until _start
      endcase
    end
  end

endmodule : draw_rectangle_stream
